// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder: adds two NIBBLES*4-bit operands one nibble per cycle through a single
// 4-bit ripple-carry adder. Define NIBBLE_ADD_SUB_EN to add a 'sub' port for A-B operation.

module nibble_rca4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);
  logic [4:0] c;

  assign c[0] = ci_i;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign co_o = c[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   busy
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     res_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [3:0]       add_sum;
  logic             add_co;
  logic [W-1:0]     b_load;
  logic             carry_load;

  // Only the low nibbles and the carry register feed the adder; no carry path crosses nibbles.
  nibble_rca4 u_rca (
    .a_i  (a_q[3:0]),
    .b_i  (b_q[3:0]),
    .ci_i (carry_q),
    .s_o  (add_sum),
    .co_o (add_co)
  );

`ifdef NIBBLE_ADD_SUB_EN
  // Subtraction as A + ~B + 1; cout=1 then means no borrow.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub | cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: data registers are reset too, so an abort leaves no stale partial result visible.
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b_load;
            carry_q    <= carry_load;
            idx_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          res_q   <= {add_sum, res_q[W-1:4]};
          carry_q <= add_co;
          a_q     <= {4'b0, a_q[W-1:4]};
          b_q     <= {4'b0, b_q[W-1:4]};
          if (idx_q == LAST_IDX) begin
            idx_q       <= '0;
            cout_q      <= add_co;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = res_q;
  assign cout      = cout_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (NIBBLES=4): latency, arithmetic, backpressure,
// mid-operation reset and back-to-back streaming; subtract vectors when NIBBLE_ADD_SUB_EN is set.

module tb_nibble_serial_add_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NIBBLE_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operand set for exactly one accepting edge.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic sv);
    a        = av;
    b        = bv;
    cin      = cv;
    sub      = sv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges after the accept until out_valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv, input logic [W-1:0] exp_sum,
                        input logic exp_cout);
    int n;
    out_ready = 1'b1;
    accept(av, bv, cv, sv);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    wait_valid(n);
    check({tag, "_latency"}, n, NIBBLES);
    check({tag, "_sum"}, {16'b0, sum}, {16'b0, exp_sum});
    check({tag, "_cout"}, {31'b0, cout}, {31'b0, exp_cout});
    tick();
    check({tag, "_release"}, {29'b0, out_valid, in_ready, busy}, {29'b0, 3'b010});
  endtask

  logic [W-1:0] bb_a    [3] = '{16'h7FFF, 16'hFFFF, 16'h0F0F};
  logic [W-1:0] bb_b    [3] = '{16'h0001, 16'hFFFF, 16'hF0F0};
  logic         bb_c    [3] = '{1'b0, 1'b1, 1'b1};
  logic [W-1:0] bb_sum  [3] = '{16'h8000, 16'hFFFF, 16'h0000};
  logic         bb_cout [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    int n;
    int acc;
    int got;
    int cyc;
    int last_acc;
    logic will_acc;
    logic will_take;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    tick();
    check("reset_flags", {29'b0, in_ready, out_valid, busy}, {29'b0, 3'b100});
    check("reset_sum", {15'b0, cout, sum}, 32'h0);
    reset_n = 1'b1;
    tick();

    run_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("cin", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0);

    // Backpressure: stall ten cycles in DONE while new operands are offered.
    out_ready = 1'b0;
    accept(16'h8000, 16'h8001, 1'b0, 1'b0);
    wait_valid(n);
    check("bp_latency", n, NIBBLES);
    a        = 16'h1111;
    b        = 16'h1111;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_stall", {12'b0, out_valid, in_ready, cout, busy, sum},
            {12'b0, 4'b1011, 16'h0001});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", {29'b0, out_valid, in_ready, busy}, {29'b0, 3'b010});
    run_op("bp_next", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0);

    // Reset two RUN cycles into an operation.
    accept(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("abort_flags", {29'b0, in_ready, out_valid, busy}, {29'b0, 3'b100});
    check("abort_sum", {15'b0, cout, sum}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    run_op("post_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);

    // Back-to-back stream with in_valid held high.
    acc       = 0;
    got       = 0;
    cyc       = 0;
    last_acc  = 0;
    out_ready = 1'b1;
    a         = bb_a[0];
    b         = bb_b[0];
    cin       = bb_c[0];
    in_valid  = 1'b1;
    while (got < 3 && cyc < 60) begin
      will_acc  = in_valid && in_ready;
      will_take = out_valid && out_ready;
      if (will_take) begin
        check("b2b_sum", {16'b0, sum}, {16'b0, bb_sum[got]});
        check("b2b_cout", {31'b0, cout}, {31'b0, bb_cout[got]});
        got++;
      end
      tick();
      cyc++;
      if (will_acc) begin
        if (acc > 0) check("b2b_period", cyc - last_acc, NIBBLES + 2);
        last_acc = cyc;
        acc++;
        if (acc < 3) begin
          a   = bb_a[acc];
          b   = bb_b[acc];
          cin = bb_c[acc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("b2b_results", got, 3);
    check("b2b_accepts", acc, 3);
    tick();

`ifdef NIBBLE_ADD_SUB_EN
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    run_op("sub_off", 16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
